// File: rtl/matriz_serializador.sv
// -----------------------------------------------------------------------------
// matriz_serializador
//
// Purpose:
//   Takes one packed N_ELEM x ELEM_W result matrix, plus its overflow flag,
//   from the ALU matrix unit and sends it on to the write-back path. The matrix
//   is captured on a start pulse and then sent one element per beat over a
//   valid/ready handshake, in row-major order (element 0 first).
//
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   start         capture request; honoured only while idle
//   matriz_in     packed matrix, element i = matriz_in[i*ELEM_W +: ELEM_W]
//   overflow_in   overflow flag accompanying matriz_in
//   elem_out      current element (passed through unmodified)
//   elem_idx      index of elem_out
//   elem_valid    elem_out / elem_idx / elem_last are valid
//   elem_ready    sink accepts the beat when elem_valid & elem_ready
//   elem_last     marks the beat with index N_ELEM-1
//   overflow_out  overflow_in latched at capture, held until the next capture
//   busy          high while sending and during the done cycle
//   done          one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module matriz_serializador #(
    parameter int unsigned N_ELEM = 25,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [N_ELEM*ELEM_W-1:0] matriz_in,
    input  logic                     overflow_in,
    output logic [ELEM_W-1:0]        elem_out,
    output logic [IDX_W-1:0]         elem_idx,
    output logic                     elem_valid,
    input  logic                     elem_ready,
    output logic                     elem_last,
    output logic                     overflow_out,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_t;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_ELEM - 1);

    state_t                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [N_ELEM*ELEM_W-1:0]   shadow_q;
    logic                       overflow_q;

    logic                       in_send;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            shadow_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Capture happens only here, so a start while busy can never
                    // disturb the shadow copy or the latched overflow flag.
                    if (start) begin
                        shadow_q   <= matriz_in;
                        overflow_q <= overflow_in;
                        idx_q      <= '0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    // elem_valid is constant in this state, so acceptance is just ready.
                    if (elem_ready) begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from state, idx and the shadow copy only; elem_ready
    // steers the next state but never feeds an output combinationally.
    always_comb begin
        in_send      = (state_q == StSend);
        elem_valid   = in_send;
        elem_idx     = idx_q;
        elem_last    = in_send && (idx_q == LastIdx);
        elem_out     = '0;
        if (in_send) begin
            elem_out = shadow_q[32'(idx_q) * ELEM_W +: ELEM_W];
        end
        overflow_out = overflow_q;
        busy         = (state_q == StSend) || (state_q == StDone);
        done         = (state_q == StDone);
    end

endmodule

// File: tb/tb_matriz_serializador.sv
module tb_matriz_serializador;

    localparam int unsigned N_ELEM = 25;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned IDX_W  = 5;

    logic                     clk;
    logic                     reset_n;
    logic                     start;
    logic [N_ELEM*ELEM_W-1:0] matriz_in;
    logic                     overflow_in;
    logic [ELEM_W-1:0]        elem_out;
    logic [IDX_W-1:0]         elem_idx;
    logic                     elem_valid;
    logic                     elem_ready;
    logic                     elem_last;
    logic                     overflow_out;
    logic                     busy;
    logic                     done;

    int passed;
    int total;

    matriz_serializador #(
        .N_ELEM (N_ELEM),
        .ELEM_W (ELEM_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .matriz_in    (matriz_in),
        .overflow_in  (overflow_in),
        .elem_out     (elem_out),
        .elem_idx     (elem_idx),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .elem_last    (elem_last),
        .overflow_out (overflow_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge; all sampling and driving
    // happens here, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Element i = base + i.
    function automatic logic [N_ELEM*ELEM_W-1:0] mk(input logic [7:0] base);
        logic [N_ELEM*ELEM_W-1:0] m;
        for (int i = 0; i < N_ELEM; i++) m[i*ELEM_W +: ELEM_W] = base + 8'(i);
        return m;
    endfunction

    // Expects the stream to be in SEND at idx 0; ready held high. Optionally
    // pulses start at beat mid_start and, for corrupt != 0, overwrites
    // matriz_in / overflow_in during the stream. Ends in the DONE cycle.
    task automatic run_full(input logic [7:0] base, input logic ovf, input int mid_start,
                            input bit corrupt);
        elem_ready = 1'b1;
        if (corrupt) begin
            matriz_in   = {N_ELEM{8'hFF}};
            overflow_in = 1'b0;
        end
        for (int i = 0; i < N_ELEM; i++) begin
            check($sformatf("valid[%0d]", i), 32'(elem_valid), 32'd1);
            check($sformatf("data[%0d]", i), 32'(elem_out), 32'(8'(base + 8'(i))));
            check($sformatf("idx[%0d]", i), 32'(elem_idx), 32'(i));
            check($sformatf("last[%0d]", i), 32'(elem_last), 32'(i == N_ELEM - 1));
            check($sformatf("ovf[%0d]", i), 32'(overflow_out), 32'(ovf));
            start = (i == mid_start);
            tick();
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_valid", 32'(elem_valid), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        passed      = 0;
        total       = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        matriz_in   = '0;
        overflow_in = 1'b0;
        elem_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(elem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow_out), 32'd0);
        check("rst_idx", 32'(elem_idx), 32'd0);
        check("rst_data", 32'(elem_out), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1) Full matrix, ready held high; first beat one cycle after start
        matriz_in = mk(8'h01);
        start     = 1'b1;
        tick();
        start = 1'b0;
        run_full(8'h01, 1'b0, -1, 1'b0);
        tick();
        check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_valid", 32'(elem_valid), 32'd0);

        // 2) Ready pattern 1,0,0 repeating; every beat exactly once, held when stalled
        start = 1'b1;
        tick();
        start = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < N_ELEM && cyc < 200) begin
            elem_ready = (cyc % 3 == 0);
            check($sformatf("t2_valid[%0d]", cyc), 32'(elem_valid), 32'd1);
            check($sformatf("t2_data[%0d]", cyc), 32'(elem_out), 32'(k + 1));
            check($sformatf("t2_idx[%0d]", cyc), 32'(elem_idx), 32'(k));
            check($sformatf("t2_done[%0d]", cyc), 32'(done), 32'd0);
            tick();
            if (elem_ready) k++;
            cyc++;
        end
        check("t2_bound", 32'(k), 32'(N_ELEM));
        elem_ready = 1'b0;
        check("t2_done_pulse", 32'(done), 32'd1);
        tick();
        check("t2_after_done", 32'(done), 32'd0);
        check("t2_after_busy", 32'(busy), 32'd0);

        // 3) Overflow latched at capture; input changes and mid-stream start ignored
        matriz_in   = mk(8'h01);
        overflow_in = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        run_full(8'h01, 1'b1, 7, 1'b1);
        tick();
        check("t3_ovf_held", 32'(overflow_out), 32'd1);
        check("t3_idle_busy", 32'(busy), 32'd0);
        tick();
        check("t3_no_restart", 32'(elem_valid), 32'd0);

        // 4) Reset after beat 10 is accepted aborts without done
        matriz_in   = mk(8'h01);
        overflow_in = 1'b1;
        start       = 1'b1;
        tick();
        start      = 1'b0;
        elem_ready = 1'b1;
        for (int i = 0; i <= 10; i++) tick();
        check("t4_pre_idx", 32'(elem_idx), 32'd11);
        check("t4_pre_ovf", 32'(overflow_out), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t4_valid", 32'(elem_valid), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ovf", 32'(overflow_out), 32'd0);
        check("t4_idx", 32'(elem_idx), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        tick();
        check("t4_done_next", 32'(done), 32'd0);
        overflow_in = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        run_full(8'h01, 1'b0, -1, 1'b0);

        // 5) Back-to-back: start in the IDLE cycle right after done
        matriz_in   = mk(8'h80);
        overflow_in = 1'b1;
        tick();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_ovf", 32'(overflow_out), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_full(8'h80, 1'b1, -1, 1'b0);
        tick();
        check("t5_final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
